hot_vector_scanner: RTL and testbench



---
 rtl/hot_vector_pkg.sv | 29 ++
 rtl/hot_vector_scanner_encoder.sv | 33 +++
 rtl/hot_vector_scanner.sv | 124 ++++++++++++
 tb/tb_hot_vector_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hot_vector_pkg.sv
//------------------------------------------------------------------------------
// Module : hot_vector_pkg
// Brief  : Shared defaults, FSM state type and sizing helpers for the scanner.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package hot_vector_pkg;

  localparam int DEF_WIDTH = 98;
  localparam int DEF_GROUP = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Index width that never collapses to zero bits for a single-entry encoder.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int group_count(input int width, input int group);
    return (width + group - 1) / group;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hot_vector_scanner_encoder.sv
//------------------------------------------------------------------------------
// Module : priority_encoder_lsb
// Brief  : LSB-first priority encoder; reports the lowest set bit of vec.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module priority_encoder_lsb
  import hot_vector_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan downward so the lowest set bit is the last assignment to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hot_vector_scanner.sv
//------------------------------------------------------------------------------
// Module : hot_vector_scanner
// Brief  : Serialises every set bit of a captured hot vector, lowest first.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hot_vector_scanner
  import hot_vector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] hot_vector_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic             last_o,
  output logic             zero_o
);

  localparam int NGROUP = group_count(WIDTH, GROUP);
  localparam int SUB_W  = idx_width(GROUP);
  localparam int GRP_W  = idx_width(NGROUP);
  localparam int FULL_W = GRP_W + SUB_W;

  scan_state_t r_state, w_state_next;
  logic [WIDTH-1:0] r_pending, w_pending_next;
  logic             r_zero, w_zero_next;

  logic [NGROUP*GROUP-1:0] w_padded;
  logic [NGROUP*SUB_W-1:0] w_sub_flat;
  logic [NGROUP-1:0]       w_grp_valid;
  logic [GRP_W-1:0]        w_grp_idx;
  logic                    w_grp_any;
  logic [SUB_W-1:0]        w_sub_sel;
  logic [FULL_W-1:0]       w_full_idx;
  logic [WIDTH-1:0]        w_rest;
  logic                    w_scan, w_last, w_load_fire, w_idx_fire;

  // Partial last group: bits beyond WIDTH read as zero.
  always_comb begin
    w_padded              = '0;
    w_padded[WIDTH-1:0]   = r_pending;
  end

  generate
    for (genvar g = 0; g < NGROUP; g++) begin : g_group_enc
      priority_encoder_lsb #(.N(GROUP)) u_sub_enc (
        .vec   (w_padded[g*GROUP +: GROUP]),
        .idx   (w_sub_flat[g*SUB_W +: SUB_W]),
        .valid (w_grp_valid[g])
      );
    end
  endgenerate

  priority_encoder_lsb #(.N(NGROUP)) u_grp_enc (
    .vec   (w_grp_valid),
    .idx   (w_grp_idx),
    .valid (w_grp_any)
  );

  always_comb begin
    w_sub_sel = '0;
    for (int g = 0; g < NGROUP; g++) begin
      if (w_grp_idx == GRP_W'(g)) w_sub_sel = w_sub_flat[g*SUB_W +: SUB_W];
    end
  end

  assign w_full_idx = {w_grp_idx, w_sub_sel};

  // Clearing the lowest set bit is exactly clearing bit idx_o.
  assign w_rest = r_pending & (r_pending - WIDTH'(1));

  assign w_scan       = (r_state == ST_SCAN);
  assign w_last       = w_scan & w_grp_any & (w_rest == '0);
  assign idx_valid_o  = w_scan;
  assign idx_o        = w_scan ? w_full_idx[IDX_W-1:0] : '0;
  assign last_o       = w_last;
  assign load_ready_o = ~w_scan | (w_last & idx_ready_i);
  assign zero_o       = r_zero;

  assign w_load_fire = load_valid_i & load_ready_o;
  assign w_idx_fire  = w_scan & idx_ready_i;

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_zero_next    = 1'b0;
    if (w_idx_fire) begin
      w_pending_next = w_rest;
      if (w_last) w_state_next = ST_IDLE;
    end
    if (w_load_fire) begin
      w_pending_next = hot_vector_i;
      if (hot_vector_i != '0) begin
        w_state_next = ST_SCAN;
      end else begin
        w_state_next = ST_IDLE;
        w_zero_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_zero    <= w_zero_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hot_vector_scanner.sv
//------------------------------------------------------------------------------
// Module : tb_hot_vector_scanner
// Brief  : Scoreboard bench for hot_vector_scanner with per-scenario tasks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hot_vector_scanner;

  localparam int W     = 98;
  localparam int IDX_W = 7;

  logic             clk;
  logic             reset_n;
  logic [W-1:0]     hot_vector_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic [IDX_W-1:0] idx_o;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic             last_o;
  logic             zero_o;

  int n_checks;
  int n_pass;
  int exp_idx[$];
  bit exp_last[$];

  hot_vector_scanner #(.WIDTH(W), .GROUP(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hot_vector_i (hot_vector_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .idx_o        (idx_o),
    .idx_valid_o  (idx_valid_o),
    .idx_ready_i  (idx_ready_i),
    .last_o       (last_o),
    .zero_o       (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic push_vec(input logic [W-1:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < W; i++) if (v[i]) hi = i;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        exp_idx.push_back(i);
        exp_last.push_back(i == hi);
      end
    end
  endtask

  task automatic junk_vec();
    logic [127:0] j;
    j = {$urandom, $urandom, $urandom, $urandom};
    hot_vector_i = j[W-1:0];
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL rst_load_ready: got %0b expected 1", load_ready_o); else n_pass++;
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL rst_idx_valid: got %0b expected 0", idx_valid_o); else n_pass++;
    n_checks++; if (last_o !== 1'b0) $display("FAIL rst_last: got %0b expected 0", last_o); else n_pass++;
    n_checks++; if (idx_o !== '0) $display("FAIL rst_idx: got %0d expected 0", idx_o); else n_pass++;
    n_checks++; if (zero_o !== 1'b0) $display("FAIL rst_zero: got %0b expected 0", zero_o); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] v;
    int e;
    bit el;
    v = '0; v[0] = 1'b1; v[7] = 1'b1; v[8] = 1'b1; v[97] = 1'b1;
    @(posedge clk); #1;
    hot_vector_i = v; load_valid_i = 1'b1; idx_ready_i = 1'b1;
    push_vec(v);
    @(negedge clk);
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL basic_load_ready: got %0b expected 1", load_ready_o); else n_pass++;
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    junk_vec();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e  = exp_idx.pop_front();
      el = exp_last.pop_front();
      n_checks++; if (idx_valid_o !== 1'b1) $display("FAIL basic_valid: got %0b expected 1", idx_valid_o); else n_pass++;
      n_checks++; if (idx_o !== e[IDX_W-1:0]) $display("FAIL basic_idx: got %0d expected %0d", idx_o, e); else n_pass++;
      n_checks++; if (last_o !== el) $display("FAIL basic_last: got %0b expected %0b", last_o, el); else n_pass++;
      @(posedge clk); #1;
      junk_vec();
    end
    @(negedge clk);
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL basic_done_valid: got %0b expected 0", idx_valid_o); else n_pass++;
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL basic_done_ready: got %0b expected 1", load_ready_o); else n_pass++;
  endtask

  task automatic test_stall();
    logic [W-1:0] v;
    int stall;
    int e;
    v = '0; v[0] = 1'b1; v[7] = 1'b1; v[8] = 1'b1; v[97] = 1'b1;
    @(posedge clk); #1;
    hot_vector_i = v; load_valid_i = 1'b1; idx_ready_i = 1'b1;
    push_vec(v);
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    stall = 0;
    for (int c = 0; c < 12 && exp_idx.size() > 0; c++) begin
      idx_ready_i = !(exp_idx[0] == 8 && stall < 3);
      if (!idx_ready_i) stall++;
      @(negedge clk);
      e = exp_idx[0];
      n_checks++; if (idx_valid_o !== 1'b1) $display("FAIL stall_valid: got %0b expected 1", idx_valid_o); else n_pass++;
      n_checks++; if (idx_o !== e[IDX_W-1:0]) $display("FAIL stall_idx: got %0d expected %0d", idx_o, e); else n_pass++;
      n_checks++; if (last_o !== exp_last[0]) $display("FAIL stall_last: got %0b expected %0b", last_o, exp_last[0]); else n_pass++;
      if (idx_ready_i) begin
        void'(exp_idx.pop_front());
        void'(exp_last.pop_front());
      end
      @(posedge clk); #1;
    end
    idx_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL stall_extra_valid: got %0b expected 0", idx_valid_o); else n_pass++;
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    hot_vector_i = '0; load_valid_i = 1'b1; idx_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (zero_o !== 1'b0) $display("FAIL zero_early: got %0b expected 0", zero_o); else n_pass++;
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (zero_o !== 1'b1) $display("FAIL zero_pulse: got %0b expected 1", zero_o); else n_pass++;
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL zero_valid: got %0b expected 0", idx_valid_o); else n_pass++;
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL zero_ready: got %0b expected 1", load_ready_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (zero_o !== 1'b0) $display("FAIL zero_width: got %0b expected 0", zero_o); else n_pass++;
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL zero_valid2: got %0b expected 0", idx_valid_o); else n_pass++;
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL zero_ready2: got %0b expected 1", load_ready_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int e;
    bit el;
    a = '0; a[96] = 1'b1;
    b = '0; b[1] = 1'b1; b[2] = 1'b1;
    @(posedge clk); #1;
    hot_vector_i = a; load_valid_i = 1'b1; idx_ready_i = 1'b1;
    push_vec(a);
    @(posedge clk); #1;
    hot_vector_i = b;
    push_vec(b);
    @(negedge clk);
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL b2b_load_ready: got %0b expected 1", load_ready_o); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      e  = exp_idx.pop_front();
      el = exp_last.pop_front();
      n_checks++; if (idx_valid_o !== 1'b1) $display("FAIL b2b_valid: got %0b expected 1", idx_valid_o); else n_pass++;
      n_checks++; if (idx_o !== e[IDX_W-1:0]) $display("FAIL b2b_idx: got %0d expected %0d", idx_o, e); else n_pass++;
      n_checks++; if (last_o !== el) $display("FAIL b2b_last: got %0b expected %0b", last_o, el); else n_pass++;
      @(posedge clk); #1;
      load_valid_i = 1'b0;
      junk_vec();
    end
    @(negedge clk);
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL b2b_done_valid: got %0b expected 0", idx_valid_o); else n_pass++;
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL b2b_done_ready: got %0b expected 1", load_ready_o); else n_pass++;
  endtask

  task automatic test_all_ones();
    logic [W-1:0] v;
    int e;
    bit el;
    v = '1;
    @(posedge clk); #1;
    hot_vector_i = v; load_valid_i = 1'b1; idx_ready_i = 1'b1;
    push_vec(v);
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      e  = exp_idx.pop_front();
      el = exp_last.pop_front();
      n_checks++; if (idx_valid_o !== 1'b1) $display("FAIL ones_valid: got %0b expected 1 at cycle %0d", idx_valid_o, c); else n_pass++;
      n_checks++; if (idx_o !== e[IDX_W-1:0]) $display("FAIL ones_idx: got %0d expected %0d", idx_o, e); else n_pass++;
      n_checks++; if (last_o !== el) $display("FAIL ones_last: got %0b expected %0b at idx %0d", last_o, el, e); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL ones_done_valid: got %0b expected 0", idx_valid_o); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    logic [W-1:0] v;
    int e;
    v = '1;
    @(posedge clk); #1;
    hot_vector_i = v; load_valid_i = 1'b1; idx_ready_i = 1'b1;
    push_vec(v);
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      e = exp_idx.pop_front();
      void'(exp_last.pop_front());
      n_checks++; if (idx_o !== e[IDX_W-1:0]) $display("FAIL rmid_idx: got %0d expected %0d", idx_o, e); else n_pass++;
      if (c < 40) begin
        @(posedge clk); #1;
      end
    end
    #1;
    reset_n = 1'b0;
    exp_idx.delete();
    exp_last.delete();
    @(negedge clk);
    n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL rmid_valid: got %0b expected 0", idx_valid_o); else n_pass++;
    n_checks++; if (load_ready_o !== 1'b1) $display("FAIL rmid_ready: got %0b expected 1", load_ready_o); else n_pass++;
    n_checks++; if (idx_o !== '0) $display("FAIL rmid_idx0: got %0d expected 0", idx_o); else n_pass++;
    n_checks++; if (last_o !== 1'b0) $display("FAIL rmid_last: got %0b expected 0", last_o); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (idx_valid_o !== 1'b0) $display("FAIL rmid_residual: got %0b expected 0 at cycle %0d", idx_valid_o, c); else n_pass++;
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset_n      = 1'b0;
    hot_vector_i = '0;
    load_valid_i = 1'b0;
    idx_ready_i  = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_back_to_back();
    test_all_ones();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
